mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: two-state load/store unit between the EX stage and a
// ready/valid data memory. One outstanding access at a time; every output is
// registered. Misaligned accesses and memory timeouts raise a one-cycle
// mem_err pulse.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        is_ld,
  input  logic        is_st,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_result,
  output logic        ld_valid,
  output logic        stall,
  output logic        mem_err
);

  // Counter is 4 bits wide, so only the low nibble of TIMEOUT is meaningful.
  localparam logic [3:0] TimeoutLim = 4'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] ld_result_q, ld_result_d;
  logic        ld_valid_q,  ld_valid_d;
  logic        stall_q,     stall_d;
  logic        mem_err_q,   mem_err_d;

  logic        access;
  logic        aligned;
  logic [3:0]  cnt_inc;

  assign access  = ex_valid & (is_ld | is_st);
  assign aligned = (alu_result[1:0] == 2'b00);
  assign cnt_inc = cnt_q + 4'd1;

  // Next-state and next-output computation for the IDLE/BUSY controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_result_d = ld_result_q;
    stall_d     = stall_q;
    ld_valid_d  = 1'b0;
    mem_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            state_d     = BUSY;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            stall_d     = 1'b1;
            // A combined ld+st request is treated as a load.
            mem_we_d    = ~is_ld;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_wdata_d = store_data;
          end else begin
            mem_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Completion wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          stall_d   = 1'b0;
          if (!mem_we_q) begin
            ld_result_d = mem_rdata;
            ld_valid_d  = 1'b1;
          end
        end else if (cnt_inc == TimeoutLim) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          stall_d   = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        mem_req_d = 1'b0;
        stall_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_result_q <= '0;
      ld_valid_q  <= 1'b0;
      stall_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_result_q <= ld_result_d;
      ld_valid_q  <= ld_valid_d;
      stall_q     <= stall_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_result = ld_result_q;
  assign ld_valid  = ld_valid_q;
  assign stall     = stall_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        is_ld;
  logic        is_st;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ld_result;
  logic        ld_valid;
  logic        stall;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ld_result  (ld_result),
    .ld_valid   (ld_valid),
    .stall      (stall),
    .mem_err    (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    alu_result = '0;
    store_data = '0;
  endtask

  task automatic present(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
    ex_valid   = 1'b1;
    is_ld      = ld;
    is_st      = st;
    alu_result = a;
    store_data = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    idle_inputs();

    // Reset state
    step();
    check_eq("rst_req",   32'(mem_req), 32'd0);
    check_eq("rst_we",    32'(mem_we), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_ldv",   32'(ld_valid), 32'd0);
    check_eq("rst_err",   32'(mem_err), 32'd0);
    check_eq("rst_addr",  mem_addr, 32'h0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    check_eq("rst_ldres", ld_result, 32'h0);

    // Load 0x10 completing at N+1; first accept right after reset release
    rst_n = 1'b1;
    present(1'b1, 1'b0, 32'h0000_0010, 32'hAAAA_AAAA);
    step();  // N+1
    check_eq("ld_req",   32'(mem_req), 32'd1);
    check_eq("ld_we",    32'(mem_we), 32'd0);
    check_eq("ld_addr",  mem_addr, 32'h10);
    check_eq("ld_stall", 32'(stall), 32'd1);
    check_eq("ld_ldv0",  32'(ld_valid), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    // Inputs during BUSY must be ignored
    present(1'b0, 1'b1, 32'h0000_0044, 32'h5555_5555);
    step();  // N+2
    idle_inputs();
    mem_ready = 1'b0;
    check_eq("ld_ldv",   32'(ld_valid), 32'd1);
    check_eq("ld_res",   ld_result, 32'hDEAD_BEEF);
    check_eq("ld_req0",  32'(mem_req), 32'd0);
    check_eq("ld_stall0", 32'(stall), 32'd0);
    check_eq("ld_err0",  32'(mem_err), 32'd0);
    step();
    check_eq("ld_ldv_pulse", 32'(ld_valid), 32'd0);
    check_eq("ld_ign_req",   32'(mem_req), 32'd0);

    // Store 0x20, ready in the third BUSY cycle
    present(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    step();
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      check_eq($sformatf("st_req%0d", i),   32'(mem_req), 32'd1);
      check_eq($sformatf("st_we%0d", i),    32'(mem_we), 32'd1);
      check_eq($sformatf("st_addr%0d", i),  mem_addr, 32'h20);
      check_eq($sformatf("st_wdata%0d", i), mem_wdata, 32'h1234_5678);
      check_eq($sformatf("st_ldv%0d", i),   32'(ld_valid), 32'd0);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
      step();
    end
    mem_ready = 1'b0;
    check_eq("st_done_req", 32'(mem_req), 32'd0);
    check_eq("st_no_ldv",   32'(ld_valid), 32'd0);
    check_eq("st_ldres",    ld_result, 32'hDEAD_BEEF);
    check_eq("st_no_err",   32'(mem_err), 32'd0);

    // Load timeout: 15 BUSY cycles, then one mem_err pulse
    present(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    step();
    idle_inputs();
    for (int i = 1; i <= 15; i++) begin
      check_eq($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
      check_eq($sformatf("to_err%0d", i), 32'(mem_err), 32'd0);
      step();
    end
    check_eq("to_req_end", 32'(mem_req), 32'd0);
    check_eq("to_err",     32'(mem_err), 32'd1);
    check_eq("to_ldv",     32'(ld_valid), 32'd0);
    check_eq("to_stall",   32'(stall), 32'd0);
    check_eq("to_ldres",   ld_result, 32'hDEAD_BEEF);
    step();
    check_eq("to_err_pulse", 32'(mem_err), 32'd0);
    check_eq("to_idle_req",  32'(mem_req), 32'd0);

    // Ready in the 15th BUSY cycle: completion wins
    present(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    step();
    idle_inputs();
    for (int i = 1; i <= 15; i++) begin
      check_eq($sformatf("tr_req%0d", i), 32'(mem_req), 32'd1);
      if (i == 15) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
      end
      step();
    end
    mem_ready = 1'b0;
    check_eq("tr_ldv",   32'(ld_valid), 32'd1);
    check_eq("tr_err",   32'(mem_err), 32'd0);
    check_eq("tr_ldres", ld_result, 32'hCAFE_F00D);
    step();
    check_eq("tr_err_late", 32'(mem_err), 32'd0);

    // Misaligned load 0x13
    present(1'b1, 1'b0, 32'h0000_0013, 32'h0);
    step();
    idle_inputs();
    check_eq("mis_req",   32'(mem_req), 32'd0);
    check_eq("mis_err",   32'(mem_err), 32'd1);
    check_eq("mis_stall", 32'(stall), 32'd0);
    step();
    check_eq("mis_err_pulse", 32'(mem_err), 32'd0);
    check_eq("mis_req2",      32'(mem_req), 32'd0);

    // ld and st together: treated as a load
    present(1'b1, 1'b1, 32'h0000_0030, 32'h7777_7777);
    step();
    idle_inputs();
    check_eq("both_we",  32'(mem_we), 32'd0);
    check_eq("both_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_CAFE;
    step();
    mem_ready = 1'b0;
    check_eq("both_ldv", 32'(ld_valid), 32'd1);
    check_eq("both_res", ld_result, 32'h0BAD_CAFE);

    // Back-to-back loads, second presented in the first's ld_valid cycle
    present(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    step();
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_ready = 1'b0;
    check_eq("b2b_ldv1", 32'(ld_valid), 32'd1);
    check_eq("b2b_res1", ld_result, 32'h1111_1111);
    present(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    step();
    idle_inputs();
    check_eq("b2b_req2",  32'(mem_req), 32'd1);
    check_eq("b2b_addr2", mem_addr, 32'h104);
    check_eq("b2b_ldv_gap", 32'(ld_valid), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h2222_2222;
    step();
    mem_ready = 1'b0;
    check_eq("b2b_ldv2", 32'(ld_valid), 32'd1);
    check_eq("b2b_res2", ld_result, 32'h2222_2222);

    // Reset mid-BUSY, asserted between clock edges
    present(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    step();
    idle_inputs();
    check_eq("mr_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_req_async",   32'(mem_req), 32'd0);
    check_eq("mr_stall_async", 32'(stall), 32'd0);
    check_eq("mr_ldres_async", ld_result, 32'h0);
    check_eq("mr_addr_async",  mem_addr, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq($sformatf("mr_ldv%0d", i), 32'(ld_valid), 32'd0);
      check_eq($sformatf("mr_err%0d", i), 32'(mem_err), 32'd0);
      check_eq($sformatf("mr_req%0d", i), 32'(mem_req), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls
  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation exceeded time bound, errors=%0d checks=%0d", errors, checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
